// File: rtl/keypad_pkg.sv
// Shared widths and FSM state type for the keypad receive path.
package keypad_pkg;

  localparam int CODE_W   = 4;
  localparam int ONEHOT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } kd_state_t;

endpackage

// File: rtl/keycode_decoder_if.sv
// Encoder-to-decoder bus: key code and strobe in, decoded press status out.
interface keycode_decoder_if
  import keypad_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic [CODE_W-1:0]   code;
  logic                strobe;
  logic [ONEHOT_W-1:0] onehot;
  logic                valid;
  logic [CODE_W-1:0]   last_code;
  logic [CNT_W-1:0]    evt_count;

  modport master (
    output code,
    output strobe,
    input  onehot,
    input  valid,
    input  last_code,
    input  evt_count
  );

  modport slave (
    input  code,
    input  strobe,
    output onehot,
    output valid,
    output last_code,
    output evt_count
  );

endinterface

// File: rtl/dec4to16.sv
// Combinational 4-to-16 decoder: decoded = 1 << code.
module dec4to16
  import keypad_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] decoded
);

  always_comb begin
    decoded       = '0;
    decoded[code] = 1'b1;
  end

endmodule

// File: rtl/keycode_decoder.sv
// Press detector: registers a one-hot key vector for HOLD_TICKS cycles per
// strobe rising edge, retriggerable, with a sticky last code and event count.
module keycode_decoder
  import keypad_pkg::*;
#(
  parameter int HOLD_TICKS = 100,
  parameter int CNT_W      = 8
) (
  input logic             hz100,
  input logic             reset,
  keycode_decoder_if.slave bus
);

  localparam int                 TIMER_W    = $clog2(HOLD_TICKS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_TICKS - 1);

  kd_state_t           state, state_d;
  logic                strobe_q;
  logic                rise;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [ONEHOT_W-1:0] decoded;
  logic [ONEHOT_W-1:0] onehot_q, onehot_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   last_code_q, last_code_d;
  logic [CNT_W-1:0]    evt_q, evt_d;

  dec4to16 u_dec (
    .code    (bus.code),
    .decoded (decoded)
  );

  // strobe_q resets high so a key held through reset release is not a press
  always_ff @(posedge hz100) begin
    if (reset) begin
      state       <= IDLE;
      strobe_q    <= 1'b1;
      timer       <= '0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      last_code_q <= '0;
      evt_q       <= '0;
    end else begin
      state       <= state_d;
      strobe_q    <= bus.strobe;
      timer       <= timer_d;
      onehot_q    <= onehot_d;
      valid_q     <= valid_d;
      last_code_q <= last_code_d;
      evt_q       <= evt_d;
    end
  end

  // A rise takes priority over expiry, so a press on the last hold cycle
  // extends the hold without valid ever dropping.
  always_comb begin
    rise        = bus.strobe & ~strobe_q;
    state_d     = state;
    timer_d     = timer;
    onehot_d    = onehot_q;
    valid_d     = valid_q;
    last_code_d = last_code_q;
    evt_d       = evt_q;

    case (state)
      IDLE: begin
        if (rise) begin
          state_d     = HOLD;
          timer_d     = TIMER_LOAD;
          onehot_d    = decoded;
          valid_d     = 1'b1;
          last_code_d = bus.code;
          evt_d       = evt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (rise) begin
          state_d     = HOLD;
          timer_d     = TIMER_LOAD;
          onehot_d    = decoded;
          valid_d     = 1'b1;
          last_code_d = bus.code;
          evt_d       = evt_q + CNT_W'(1);
        end else if (timer == '0) begin
          state_d  = IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  assign bus.onehot    = onehot_q;
  assign bus.valid     = valid_q;
  assign bus.last_code = last_code_q;
  assign bus.evt_count = evt_q;

endmodule

// File: tb/tb_keycode_decoder.sv
// Bench for keycode_decoder: a long-hold instance and a 1-cycle-hold instance,
// both compared every cycle against a press-history reference model.
module tb_keycode_decoder;
  import keypad_pkg::*;

  localparam int CNT_W = 8;
  localparam int HOLD0 = 100;
  localparam int HOLD1 = 1;
  localparam int OBS_W = ONEHOT_W + 1 + CODE_W + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst    [2];
  logic              strobe [2];
  logic [CODE_W-1:0] code   [2];

  keycode_decoder_if #(.CNT_W(CNT_W)) if0 ();
  keycode_decoder_if #(.CNT_W(CNT_W)) if1 ();

  assign if0.strobe = strobe[0];
  assign if0.code   = code[0];
  assign if1.strobe = strobe[1];
  assign if1.code   = code[1];

  keycode_decoder #(.HOLD_TICKS(HOLD0), .CNT_W(CNT_W)) dut0 (
    .hz100 (clk),
    .reset (rst[0]),
    .bus   (if0)
  );

  keycode_decoder #(.HOLD_TICKS(HOLD1), .CNT_W(CNT_W)) dut1 (
    .hz100 (clk),
    .reset (rst[1]),
    .bus   (if1)
  );

  logic [OBS_W-1:0] obs [2];
  assign obs[0] = {if0.onehot, if0.valid, if0.last_code, if0.evt_count};
  assign obs[1] = {if1.onehot, if1.valid, if1.last_code, if1.evt_count};

  // Reference model: remembers when the latest press happened and what it was;
  // the outputs are valid while fewer than HOLD cycles have passed since it.
  int               m_cyc   [2] = '{0, 0};
  int               m_press [2] = '{0, 0};
  int               m_cnt   [2] = '{0, 0};
  bit               m_have  [2] = '{1'b0, 1'b0};
  bit               m_prev  [2] = '{1'b1, 1'b1};
  logic [CODE_W-1:0] m_code [2];
  logic [OBS_W-1:0] expv    [2];

  always @(posedge clk) begin
    int  hold;
    bit  v;
    for (int i = 0; i < 2; i++) begin
      hold     = (i == 0) ? HOLD0 : HOLD1;
      m_cyc[i] = m_cyc[i] + 1;
      if (rst[i]) begin
        m_have[i] = 1'b0;
        m_prev[i] = 1'b1;
        m_cnt[i]  = 0;
        m_code[i] = '0;
      end else begin
        if (strobe[i] && !m_prev[i]) begin
          m_press[i] = m_cyc[i];
          m_code[i]  = code[i];
          m_cnt[i]   = m_cnt[i] + 1;
          m_have[i]  = 1'b1;
        end
        m_prev[i] = strobe[i];
      end
      v       = m_have[i] && ((m_cyc[i] - m_press[i]) < hold);
      expv[i] = {(v ? (16'd1 << m_code[i]) : 16'd0), v, m_code[i], CNT_W'(m_cnt[i] % 256)};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; strobe[i] = 1'b0; code[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== '0) begin
        n_err++;
        $display("FAIL reset dut%0d got %h want 0", i, obs[i]);
      end
      n_vec++;
      if (obs[i] !== expv[i]) begin
        n_err++;
        $display("FAIL reset_model dut%0d got %h want %h", i, obs[i], expv[i]);
      end
      rst[i] = 1'b0;
    end
  endtask

  task automatic test_single_press;
    int on_cycles = 0;
    @(negedge clk);
    code[0] = 4'd5; strobe[0] = 1'b1;
    for (int k = 0; k < 115; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs[0] !== expv[0]) begin
        n_err++;
        $display("FAIL single_press k=%0d got %h want %h", k, obs[0], expv[0]);
      end
      if (if0.onehot === 16'h0020) on_cycles++;
      if (k == 9)  strobe[0] = 1'b0;
      if (k == 20) code[0] = 4'($urandom);
    end
    n_vec++;
    if (on_cycles !== HOLD0) begin
      n_err++;
      $display("FAIL single_press_len got %0d want %0d", on_cycles, HOLD0);
    end
    n_vec++;
    if (if0.evt_count !== 8'd1) begin
      n_err++;
      $display("FAIL single_press_cnt got %0d want 1", if0.evt_count);
    end
  endtask

  task automatic test_retrigger;
    int on9 = 0;
    for (int k = 0; k < 150; k++) begin
      strobe[0] = (k < 3) || (k >= 40 && k < 45);
      code[0]   = (k < 40) ? 4'd5 : 4'd9;
      @(negedge clk);
      n_vec++;
      if (obs[0] !== expv[0]) begin
        n_err++;
        $display("FAIL retrigger k=%0d got %h want %h", k, obs[0], expv[0]);
      end
      if (if0.onehot === 16'h0200) on9++;
    end
    n_vec++;
    if (on9 !== HOLD0 || if0.last_code !== 4'd9 || if0.evt_count !== 8'd3) begin
      n_err++;
      $display("FAIL retrigger_end got len=%0d code=%0d cnt=%0d want len=%0d code=9 cnt=3",
               on9, if0.last_code, if0.evt_count, HOLD0);
    end
  endtask

  task automatic test_rise_at_expiry;
    for (int k = 0; k < 210; k++) begin
      strobe[0] = (k < 2) || (k == HOLD0) || (k == HOLD0 + 1);
      code[0]   = (k < HOLD0) ? 4'd2 : 4'd14;
      @(negedge clk);
      n_vec++;
      if (obs[0] !== expv[0]) begin
        n_err++;
        $display("FAIL expiry k=%0d got %h want %h", k, obs[0], expv[0]);
      end
      if (k < 2 * HOLD0 && if0.valid !== 1'b1) begin
        n_err++;
        $display("FAIL expiry_valid k=%0d got %b want 1", k, if0.valid);
      end
    end
  endtask

  task automatic test_wrap;
    logic [CODE_W-1:0]   c;
    logic [ONEHOT_W-1:0] want;
    for (int p = 0; p < 256; p++) begin
      c         = 4'($urandom);
      want      = 16'd1 << c;
      code[1]   = c;
      strobe[1] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (if1.onehot !== want || obs[1] !== expv[1]) begin
        n_err++;
        $display("FAIL wrap_on p=%0d got %h want %h", p, if1.onehot, want);
      end
      strobe[1] = 1'b0;
      @(negedge clk);
      n_vec++;
      if (if1.onehot !== '0 || obs[1] !== expv[1]) begin
        n_err++;
        $display("FAIL wrap_off p=%0d got %h want 0", p, if1.onehot);
      end
    end
    n_vec++;
    if (if1.evt_count !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_cnt got %0d want 0", if1.evt_count);
    end
  endtask

  task automatic test_reset_cases;
    strobe[0] = 1'b1; code[0] = 4'd7; rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (if0.valid !== 1'b0 || obs[0] !== expv[0]) begin
        n_err++;
        $display("FAIL held_through_reset k=%0d got %h want %h", k, obs[0], expv[0]);
      end
    end
    strobe[0] = 1'b0;
    @(negedge clk);
    strobe[0] = 1'b1; code[0] = 4'd3;
    repeat (4) @(negedge clk);
    n_vec++;
    if (if0.onehot !== 16'h0008 || obs[0] !== expv[0]) begin
      n_err++;
      $display("FAIL press_before_reset got %h want 0008", if0.onehot);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs[0] !== '0) begin
      n_err++;
      $display("FAIL mid_hold_reset got %h want 0", obs[0]);
    end
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs[0] !== '0 || obs[0] !== expv[0]) begin
      n_err++;
      $display("FAIL after_reset got %h want 0", obs[0]);
    end
    strobe[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) strobe[0] = ~strobe[0];
      strobe[1] = 1'($urandom);
      code[0]   = 4'($urandom);
      code[1]   = 4'($urandom);
      rst[0]    = ($urandom_range(0, 499) == 0);
      rst[1]    = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs[i] !== expv[i]) begin
          n_err++;
          $display("FAIL random k=%0d dut%0d got %h want %h", k, i, obs[i], expv[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_retrigger();
    test_rise_at_expiry();
    test_wrap();
    test_reset_cases();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
